pulpino_pad_mux: RTL

Parametrised pad multiplexer and safe-reconfiguration controller placed between the chip top and the pad cells. It routes one of `N_FUNC` peripheral functions to each of `N_PADS` bidirectional pads, synchronises pad inputs into the core clock domain, and runs a per-request isolate/settle/switch sequence so that no pad is ever driven by two functions during a function change. It is the generalised successor to the fixed GPIO/UPIO pad wiring at the chip top.

---
 rtl/pulpino_pad_pkg.sv | 34 +++
 rtl/pulpino_pad_in_sync.sv | 70 +++++++
 rtl/pulpino_pad_mux.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pulpino_pad_pkg.sv
// Shared types and width helpers for the pad multiplexer.
// RESET_FUNC is the function every pad returns to on reset.
package pulpino_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_SWITCH  = 2'd3
  } pad_fsm_e;

  localparam int unsigned RESET_FUNC = 0;

  // Width of a stored function select.
  function automatic int unsigned fsel_w(input int unsigned n_func);
    return (n_func > 1) ? $clog2(n_func) : 1;
  endfunction

  // Request index widths carry one extra code point so out-of-range
  // indices can actually be presented and flagged as errors.
  function automatic int unsigned pad_idx_w(input int unsigned n_pads);
    return $clog2(n_pads + 1);
  endfunction

  function automatic int unsigned func_idx_w(input int unsigned n_func);
    return $clog2(n_func + 1);
  endfunction

  // Width of a counter that runs 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulpino_pad_in_sync.sv
// One-bit pad input synchroniser (2 flops) with optional debounce.
// Optional feature macro: PULPINO_PAD_DEBOUNCE_EN.
// Ports:
//   clk, rst     core clock, async active-high reset
//   iso          pad is isolated: hold the last delivered value
//   pad_in       asynchronous pad input
//   sync_out     synchronised (and optionally debounced) value
module pulpino_pad_in_sync
  import pulpino_pad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic iso,
  input  logic pad_in,
  output logic sync_out
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic s1_q;
  logic s2_q;

  // Two-flop synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pad_in;
`ifdef PULPINO_PAD_DEBOUNCE_EN
      s2_q <= s1_q;
`else
      // Second stage doubles as the hold register while isolated.
      if (!iso) s2_q <= s1_q;
`endif
    end
  end

`ifdef PULPINO_PAD_DEBOUNCE_EN
  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);

  logic [DB_W-1:0] db_cnt_q;
  logic            db_q;

  // For a single bit, "differs from output" already implies "changed", so the
  // counter restarts whenever the input returns to the delivered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (iso || (s2_q == db_q)) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_q     <= s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign sync_out = db_q;
`else
  assign sync_out = s2_q;
`endif

endmodule

// File: rtl/pulpino_pad_mux.sv
// Pad multiplexer with safe isolate/settle/switch reconfiguration.
// Optional feature macro: PULPINO_PAD_DEBOUNCE_EN (input debounce).
// Ports:
//   clk, rst                 core clock, async active-high reset
//   cfg_req_i/we_i/pad_i/func_i  configuration request
//   cfg_gnt_o/err_o/rdata_o  one-cycle completion with status and readback
//   func_out_i/func_oen_i    per-function pad data / enable (flat f*N_PADS+p)
//   func_in_o                synchronised input per function (flat f*N_PADS+p)
//   pad_out_o/oen_o/ie_o     to pad cells; pad_in_i from pad cells
module pulpino_pad_mux
  import pulpino_pad_pkg::*;
#(
  parameter int unsigned N_PADS          = 32,
  parameter int unsigned N_FUNC          = 4,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_req_i,
  input  logic                              cfg_we_i,
  input  logic [pad_idx_w(N_PADS)-1:0]      cfg_pad_i,
  input  logic [func_idx_w(N_FUNC)-1:0]     cfg_func_i,
  output logic                              cfg_gnt_o,
  output logic                              cfg_err_o,
  output logic [fsel_w(N_FUNC)-1:0]         cfg_rdata_o,
  input  logic [N_FUNC*N_PADS-1:0]          func_out_i,
  input  logic [N_FUNC*N_PADS-1:0]          func_oen_i,
  output logic [N_FUNC*N_PADS-1:0]          func_in_o,
  output logic [N_PADS-1:0]                 pad_out_o,
  output logic [N_PADS-1:0]                 pad_oen_o,
  output logic [N_PADS-1:0]                 pad_ie_o,
  input  logic [N_PADS-1:0]                 pad_in_i
);

  localparam int unsigned PAD_W  = pad_idx_w(N_PADS);
  localparam int unsigned FUNC_W = func_idx_w(N_FUNC);
  localparam int unsigned FSEL_W = fsel_w(N_FUNC);
  localparam int unsigned CNT_W  = cnt_w(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  pad_fsm_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAD_W-1:0]  tgt_pad_q;
  logic [FSEL_W-1:0] tgt_func_q;
  logic [FSEL_W-1:0] fsel_q [N_PADS];

  logic              tgt_ld, fsel_we, gnt_d, err_d;
  logic [FSEL_W-1:0] rdata_d, cur_fsel;
  logic              pad_oor, func_oor, in_iso;
  logic [N_PADS-1:0] iso, out_sel, oen_sel, sync_q;

  // Current function of the requested pad; 0 for an out-of-range index.
  always_comb begin
    cur_fsel = '0;
    for (int unsigned p = 0; p < N_PADS; p++) begin
      if (cfg_pad_i == PAD_W'(p)) cur_fsel = fsel_q[p];
    end
  end

  assign pad_oor  = (cfg_pad_i >= PAD_W'(N_PADS));
  assign func_oor = (cfg_func_i >= FUNC_W'(N_FUNC));
  assign in_iso   = (state_q == ST_ISOLATE) || (state_q == ST_SETTLE);

  // Reconfiguration FSM: next state and completion outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_ld  = 1'b0;
    fsel_we = 1'b0;
    gnt_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cfg_req_i) begin
          if (pad_oor || (cfg_we_i && func_oor)) begin
            gnt_d = 1'b1;
            err_d = 1'b1;
          end else if (!cfg_we_i || (FUNC_W'(cur_fsel) == cfg_func_i)) begin
            gnt_d   = 1'b1;
            rdata_d = cur_fsel;
          end else begin
            tgt_ld  = 1'b1;
            state_d = ST_ISOLATE;
          end
        end
      end
      ST_ISOLATE: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_SWITCH;
          fsel_we = 1'b1;
          gnt_d   = 1'b1;
          rdata_d = tgt_func_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SWITCH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched target and completion registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tgt_pad_q   <= '0;
      tgt_func_q  <= '0;
      cfg_gnt_o   <= 1'b0;
      cfg_err_o   <= 1'b0;
      cfg_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_gnt_o   <= gnt_d;
      cfg_err_o   <= err_d;
      cfg_rdata_o <= rdata_d;
      if (tgt_ld) begin
        tgt_pad_q  <= cfg_pad_i;
        tgt_func_q <= FSEL_W'(cfg_func_i);
      end
    end
  end

  // Per-pad function select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < N_PADS; p++) fsel_q[p] <= FSEL_W'(RESET_FUNC);
    end else if (fsel_we) begin
      for (int unsigned p = 0; p < N_PADS; p++) begin
        if (tgt_pad_q == PAD_W'(p)) fsel_q[p] <= tgt_func_q;
      end
    end
  end

  // Per-pad function muxing, input fan-out and synchroniser.
  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    logic [N_FUNC-1:0] outs;
    logic [N_FUNC-1:0] oens;

    for (genvar f = 0; f < N_FUNC; f++) begin : g_func
      assign outs[f] = func_out_i[f*N_PADS + p];
      assign oens[f] = func_oen_i[f*N_PADS + p];
      assign func_in_o[f*N_PADS + p] = sync_q[p] & (fsel_q[p] == FSEL_W'(f));
    end

    assign out_sel[p] = outs[fsel_q[p]];
    assign oen_sel[p] = oens[fsel_q[p]];
    assign iso[p]     = in_iso & (tgt_pad_q == PAD_W'(p));

    pulpino_pad_in_sync #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_in_sync (
      .clk     (clk),
      .rst     (rst),
      .iso     (iso[p]),
      .pad_in  (pad_in_i[p]),
      .sync_out(sync_q[p])
    );
  end

  // Pad-side registers; isolation forces the driver off and the receiver off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_out_o <= '0;
      pad_oen_o <= '1;
      pad_ie_o  <= '1;
    end else begin
      pad_out_o <= out_sel;
      pad_oen_o <= oen_sel | iso;
      pad_ie_o  <= ~iso;
    end
  end

endmodule
